// File: rtl/fpgacfg_pkg.sv
// Shared types and frame constants for the FPGA-config SPI responder.
package fpgacfg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DONE
  } state_t;

  localparam int unsigned FRAME_BITS = 32;
  localparam int unsigned CMD_BITS   = 16;
  localparam int unsigned DATA_W     = 16;

endpackage

// File: rtl/fpgacfg_spi_slave_sync_edge.sv
// 2-FF synchronizer with rise/fall pulses from the synchronized value vs. its delayed copy.
module sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  // sr[1] is the synchronized level, sr[2] its one-cycle-delayed copy
  logic [2:0] sr;

  always_ff @(posedge clk) begin
    if (!reset_n) sr <= '0;
    else          sr <= {sr[1:0], d};
  end

  assign rise = sr[1] & ~sr[2];
  assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/fpgacfg_spi_slave.sv
// SPI mode-0 responder: oversampled 32-bit frame decode into single-cycle register-bank strobes.
module fpgacfg_spi_slave
  import fpgacfg_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h0000,
  parameter int unsigned AW        = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss_n,
  output logic              miso,
  output logic              miso_oe,
  output logic [AW-1:0]     reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata
);

  state_t state_q, state_d;

  logic                  sclk_rise, sclk_fall;
  logic [1:0]            mosi_ff, ss_ff;
  logic                  mosi_s, ss_s, ss_prev, ss_fall;
  logic [4:0]            cnt_q;
  logic [FRAME_BITS-2:0] sh_q;
  logic [FRAME_BITS-1:0] frame_c;
  logic [14:0]           cmd_off, frm_off;
  logic                  in_frame, edge_ok, cmd_evt, frame_evt;
  logic                  rd_hit, wr_hit, ld_q;
  logic [DATA_W-1:0]     out_sr;

  sync_edge u_sclk_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (sclk),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  // Left unreset so a reset during an active frame cannot fake an ss_n falling edge
  always_ff @(posedge clk) begin
    mosi_ff <= {mosi_ff[0], mosi};
    ss_ff   <= {ss_ff[0], ss_n};
  end

  assign mosi_s   = mosi_ff[1];
  assign ss_s     = ss_ff[1];
  assign ss_fall  = ss_prev & ~ss_s;
  assign in_frame = (state_q == CMD) || (state_q == DATA);
  assign edge_ok  = sclk_rise & ~ss_s & in_frame;

  // The 32nd frame bit is taken straight from mosi on the final edge
  assign frame_c = {sh_q, mosi_s};
  assign cmd_off = frame_c[CMD_BITS-2:0] - BASE_ADDR;
  assign frm_off = frame_c[FRAME_BITS-2:CMD_BITS] - BASE_ADDR;
  assign rd_hit  = cmd_evt & ~frame_c[CMD_BITS-1] & ((cmd_off >> AW) == '0);
  assign wr_hit  = frame_evt & frame_c[FRAME_BITS-1] & ((frm_off >> AW) == '0);
  assign miso    = out_sr[DATA_W-1];

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_evt   = 1'b0;
    frame_evt = 1'b0;
    case (state_q)
      IDLE: if (ss_fall) state_d = CMD;
      CMD: begin
        if (ss_s) state_d = IDLE;
        else if (edge_ok && cnt_q == 5'(CMD_BITS - 1)) begin
          cmd_evt = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (ss_s) state_d = IDLE;
        else if (edge_ok && cnt_q == 5'(FRAME_BITS - 1)) begin
          frame_evt = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: if (ss_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ss_prev   <= 1'b0;
      cnt_q     <= '0;
      sh_q      <= '0;
      out_sr    <= '0;
      miso_oe   <= 1'b0;
      ld_q      <= 1'b0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
    end else begin
      ss_prev <= ss_s;
      reg_rd  <= rd_hit;
      reg_wr  <= wr_hit;
      ld_q    <= reg_rd;

      if (state_q == IDLE) cnt_q <= '0;
      else if (edge_ok)    cnt_q <= cnt_q + 5'd1;

      if (edge_ok) sh_q <= frame_c[FRAME_BITS-2:0];

      if (rd_hit) reg_addr <= cmd_off[AW-1:0];
      if (wr_hit) begin
        reg_addr  <= frm_off[AW-1:0];
        reg_wdata <= frame_c[DATA_W-1:0];
      end

      // bit15 is already on miso at the load; the first DATA falling edge precedes any
      // data-phase sample, so shifting starts only after the 17th rising edge
      if (ld_q && !ss_s)
        out_sr <= reg_rdata;
      else if (sclk_fall && !ss_s && state_q == DATA && cnt_q > 5'(CMD_BITS))
        out_sr <= {out_sr[DATA_W-2:0], 1'b0};

      if (ss_s)      miso_oe <= 1'b0;
      else if (ld_q) miso_oe <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpgacfg_spi_slave.sv
// Bench for fpgacfg_spi_slave: SPI master at clk/8 against a frame-level reference model.
module tb_fpgacfg_spi_slave;

  localparam logic [14:0] BASE = 15'h0020;
  localparam int unsigned AWB  = 5;

  logic        clk = 1'b0, reset_n = 1'b0, sclk = 1'b0, mosi = 1'b0, ss_n = 1'b1;
  logic        miso, miso_oe, reg_wr, reg_rd;
  logic [4:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata = '0;

  fpgacfg_spi_slave #(.BASE_ADDR(BASE), .AW(AWB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sclk      (sclk),
    .mosi      (mosi),
    .ss_n      (ss_n),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata)
  );

  always #5 clk = ~clk;

  // Register bank driven only by DUT strobes; rdata valid the cycle after reg_rd
  bit [15:0] bank [32];
  always @(posedge clk) begin
    if (reg_wr) bank[reg_addr] <= reg_wdata;
    if (reg_rd) reg_rdata <= bank[reg_addr];
  end

  int          wr_tot = 0, rd_tot = 0, oe_tot = 0;
  logic [4:0]  mon_wr_addr = '0, mon_rd_addr = '0;
  logic [15:0] mon_wr_data = '0;
  always @(negedge clk) begin
    if (reg_wr) begin
      wr_tot      <= wr_tot + 1;
      mon_wr_addr <= reg_addr;
      mon_wr_data <= reg_wdata;
    end
    if (reg_rd) begin
      rd_tot      <= rd_tot + 1;
      mon_rd_addr <= reg_addr;
    end
    if (miso_oe) oe_tot <= oe_tot + 1;
  end

  int vectors = 0, miscompares = 0;

  // Reference model state
  bit [15:0]   model [32];
  logic [4:0]  exp_last_addr = '0, exp_waddr, exp_raddr;
  logic [15:0] exp_last_wdata = '0, exp_wdata, exp_miso, miso_mask;
  int          exp_wr, exp_rd, exp_nbits;
  bit          exp_oe;

  // Observations of the last frame
  int          obs_wr, obs_rd, obs_oe;
  logic [15:0] obs_miso;
  logic        obs_oe_after;
  logic [24:0] obs_rst;

  task automatic model_frame(input logic [31:0] f, input int n, input int rst_at);
    int         eff;
    logic [14:0] off;
    bit         hit;
    eff = (rst_at > 0 && rst_at < n) ? rst_at : n;
    off = f[30:16] - BASE;
    hit = off < 15'd32;
    exp_wr = 0; exp_rd = 0; exp_oe = 0; exp_nbits = 0;
    if (eff >= 32 && f[31] && hit) begin
      exp_wr         = 1;
      exp_waddr      = off[4:0];
      exp_wdata      = f[15:0];
      model[off[4:0]] = f[15:0];
      exp_last_addr  = off[4:0];
      exp_last_wdata = f[15:0];
    end
    if (eff >= 16 && !f[31] && hit) begin
      exp_rd        = 1;
      exp_raddr     = off[4:0];
      exp_oe        = 1;
      exp_miso      = model[off[4:0]];
      exp_nbits     = ((eff > 32) ? 32 : eff) - 16;
      exp_last_addr = off[4:0];
    end
    if (rst_at > 0 && rst_at < n) begin
      exp_last_addr  = '0;
      exp_last_wdata = '0;
    end
    miso_mask = (exp_nbits == 0) ? 16'h0000 : 16'(16'hFFFF << (16 - exp_nbits));
  endtask

  // Master: mosi changes while sclk low, miso sampled just before each rising edge
  task automatic send_frame(input logic [31:0] f, input int n, input int rst_at, input int gap);
    int w0, r0, o0;
    logic [3:0] bi;
    w0 = wr_tot; r0 = rd_tot; o0 = oe_tot;
    obs_miso = '0;
    obs_rst  = '1;
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      mosi = (i < 32) ? f[31-i] : 1'($urandom);
      repeat (4) @(negedge clk);
      if (i >= 16 && i < 32) begin
        bi = 4'(31 - i);
        obs_miso[bi] = miso;
      end
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      if (i == rst_at - 1) begin
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        obs_rst = {miso, miso_oe, reg_wr, reg_rd, reg_addr, reg_wdata};
        reset_n = 1'b1;
      end
    end
    repeat (4) @(negedge clk);
    ss_n = 1'b1;
    repeat (4) @(negedge clk);
    obs_oe_after = miso_oe;
    repeat (gap) @(negedge clk);
    obs_wr = wr_tot - w0;
    obs_rd = rd_tot - r0;
    obs_oe = oe_tot - o0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if ({miso, miso_oe, reg_wr, reg_rd, reg_addr, reg_wdata} !== 25'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", {miso, miso_oe, reg_wr, reg_rd, reg_addr, reg_wdata});
    end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write_hit;
    model_frame(32'h8025_BEEF, 32, 0);
    send_frame(32'h8025_BEEF, 32, 0, 8);
    vectors++;
    if (obs_wr !== 1) begin miscompares++; $display("FAIL wr_hit_count: got %0d want 1", obs_wr); end
    vectors++;
    if (mon_wr_addr !== 5'd5 || mon_wr_data !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL wr_hit_addr_data: got %h/%h want 05/beef", mon_wr_addr, mon_wr_data);
    end
    vectors++;
    if (obs_oe !== 0 || obs_rd !== 0) begin
      miscompares++;
      $display("FAIL wr_hit_no_oe_rd: got oe %0d rd %0d want 0 0", obs_oe, obs_rd);
    end
  endtask

  task automatic test_read_hit;
    model_frame(32'h8023_A5C3, 32, 0);
    send_frame(32'h8023_A5C3, 32, 0, 8);
    vectors++;
    if (obs_wr !== 1 || mon_wr_addr !== 5'd3) begin
      miscompares++;
      $display("FAIL rd_setup_write: got %0d@%h want 1@03", obs_wr, mon_wr_addr);
    end
    model_frame(32'h0023_0000, 32, 0);
    send_frame(32'h0023_0000, 32, 0, 8);
    vectors++;
    if (obs_rd !== 1 || mon_rd_addr !== 5'd3) begin
      miscompares++;
      $display("FAIL rd_hit_strobe: got %0d@%h want 1@03", obs_rd, mon_rd_addr);
    end
    vectors++;
    if (obs_miso !== 16'hA5C3) begin
      miscompares++;
      $display("FAIL rd_hit_miso: got %h want a5c3", obs_miso);
    end
    vectors++;
    if (obs_oe == 0 || obs_oe_after !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_hit_oe: got cycles %0d after %b want >0 and 0", obs_oe, obs_oe_after);
    end
    vectors++;
    if (obs_wr !== 0) begin miscompares++; $display("FAIL rd_hit_no_wr: got %0d want 0", obs_wr); end
  endtask

  task automatic test_miss;
    logic [31:0] frames [2];
    frames[0] = 32'h8040_1234;
    frames[1] = 32'h0040_0000;
    for (int k = 0; k < 2; k++) begin
      model_frame(frames[k], 32, 0);
      send_frame(frames[k], 32, 0, 8);
      vectors++;
      if (obs_wr !== 0 || obs_rd !== 0 || obs_oe !== 0) begin
        miscompares++;
        $display("FAIL miss_%0d: got wr %0d rd %0d oe %0d want 0 0 0", k, obs_wr, obs_rd, obs_oe);
      end
    end
  endtask

  task automatic test_abort;
    model_frame(32'h8021_FFFF, 20, 0);
    send_frame(32'h8021_FFFF, 20, 0, 8);
    vectors++;
    if (obs_wr !== 0) begin miscompares++; $display("FAIL abort_no_wr: got %0d want 0", obs_wr); end
    model_frame(32'h8021_0001, 32, 0);
    send_frame(32'h8021_0001, 32, 0, 8);
    vectors++;
    if (obs_wr !== 1 || mon_wr_addr !== 5'd1 || mon_wr_data !== 16'h0001) begin
      miscompares++;
      $display("FAIL abort_followup: got %0d@%h=%h want 1@01=0001", obs_wr, mon_wr_addr, mon_wr_data);
    end
    model_frame(32'h0021_0000, 32, 0);
    send_frame(32'h0021_0000, 32, 0, 8);
    vectors++;
    if (obs_miso !== exp_miso) begin
      miscompares++;
      $display("FAIL abort_readback: got %h want %h", obs_miso, exp_miso);
    end
  endtask

  task automatic test_back_to_back;
    model_frame(32'h8022_00AA, 40, 0);
    send_frame(32'h8022_00AA, 40, 0, 4);
    vectors++;
    if (obs_wr !== 1 || mon_wr_addr !== 5'd2 || mon_wr_data !== 16'h00AA) begin
      miscompares++;
      $display("FAIL overrun_commit: got %0d@%h=%h want 1@02=00aa", obs_wr, mon_wr_addr, mon_wr_data);
    end
    model_frame(32'h0022_0000, 32, 0);
    send_frame(32'h0022_0000, 32, 0, 8);
    vectors++;
    if (obs_rd !== 1 || obs_miso !== 16'h00AA) begin
      miscompares++;
      $display("FAIL b2b_read: got %0d rd miso %h want 1 00aa", obs_rd, obs_miso);
    end
  endtask

  task automatic test_reset_midframe;
    model_frame(32'h0025_0000, 32, 24);
    send_frame(32'h0025_0000, 32, 24, 8);
    vectors++;
    if (obs_rst !== 25'd0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got %h want 0", obs_rst);
    end
    vectors++;
    if (obs_rd !== exp_rd || (obs_miso & miso_mask) !== (exp_miso & miso_mask)) begin
      miscompares++;
      $display("FAIL midreset_partial_read: got %0d/%h want %0d/%h", obs_rd, obs_miso & miso_mask,
               exp_rd, exp_miso & miso_mask);
    end
    model_frame(32'h8024_1357, 32, 0);
    send_frame(32'h8024_1357, 32, 0, 8);
    vectors++;
    if (obs_wr !== 1 || mon_wr_addr !== 5'd4 || mon_wr_data !== 16'h1357 || reg_addr !== exp_last_addr) begin
      miscompares++;
      $display("FAIL midreset_next_frame: got %0d@%h=%h want 1@04=1357", obs_wr, mon_wr_addr, mon_wr_data);
    end
  endtask

  task automatic test_random;
    int          lens [8] = '{32, 32, 32, 32, 40, 20, 12, 24};
    logic [31:0] f;
    int          n;
    for (int k = 0; k < 36; k++) begin
      f[31]    = (k < 8) ? 1'b1 : 1'($urandom);
      f[30:16] = BASE - 15'd4 + 15'($urandom_range(0, 40));
      f[15:0]  = 16'($urandom);
      n        = lens[$urandom_range(0, 7)];
      model_frame(f, n, 0);
      send_frame(f, n, 0, 4 + $urandom_range(0, 8));
      vectors++;
      if (obs_wr !== exp_wr || (exp_wr == 1 && (mon_wr_addr !== exp_waddr || mon_wr_data !== exp_wdata))) begin
        miscompares++;
        $display("FAIL rand_wr_%0d f=%h n=%0d: got %0d@%h=%h want %0d@%h=%h", k, f, n, obs_wr,
                 mon_wr_addr, mon_wr_data, exp_wr, exp_waddr, exp_wdata);
      end
      vectors++;
      if (obs_rd !== exp_rd || (exp_rd == 1 && mon_rd_addr !== exp_raddr)) begin
        miscompares++;
        $display("FAIL rand_rd_%0d f=%h n=%0d: got %0d@%h want %0d@%h", k, f, n, obs_rd, mon_rd_addr,
                 exp_rd, exp_raddr);
      end
      vectors++;
      if ((obs_oe != 0) !== exp_oe || obs_oe_after !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_oe_%0d f=%h n=%0d: got %0d/%b want %b/0", k, f, n, obs_oe, obs_oe_after, exp_oe);
      end
      vectors++;
      if ((obs_miso & miso_mask) !== (exp_miso & miso_mask)) begin
        miscompares++;
        $display("FAIL rand_miso_%0d f=%h n=%0d: got %h want %h", k, f, n, obs_miso & miso_mask,
                 exp_miso & miso_mask);
      end
      vectors++;
      if (reg_addr !== exp_last_addr || reg_wdata !== exp_last_wdata) begin
        miscompares++;
        $display("FAIL rand_hold_%0d: got %h/%h want %h/%h", k, reg_addr, reg_wdata, exp_last_addr,
                 exp_last_wdata);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write_hit();
    test_read_hit();
    test_miss();
    test_abort();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
